up_tpl_regmap_mux: RTL
======================

# up_tpl_regmap_mux

Parametrised bus-response aggregator for TPL register maps. It sits between `up_axi` and NUM_SLAVES register sub-blocks: the common block, the per-channel blocks and `up_tpl_common`. It merges their `up_wack`/`up_rack`/`up_rdata` returns into one registered response. Unlike a plain OR-reduce, it tracks each outstanding request with a per-direction FSM. If no slave answers, it completes the transaction itself after a timeout so the AXI bus cannot hang. It also gates read data by each slave's `rack` and records sticky error status.

## Interface
Parameters:
- NUM_SLAVES, 4: number of sub-blocks, 1..64.
- DATA_WIDTH, 32: read-data width.
- TIMEOUT_CYCLES, 64: wait-state cycles before forced completion, 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_DEAD: read data returned on timeout.
- PIPELINE, 0: 1 adds one register stage after the gated OR-reduce.

Ports:
- up_clk  in  1  register-bus clock; the only clock.
- up_rstn  in  1  reset, asynchronous, active-low.
- up_wreq  in  1  write request pulse from `up_axi`.
- up_rreq  in  1  read request pulse from `up_axi`.
- up_wack_s  in  NUM_SLAVES  per-slave write acks.
- up_rack_s  in  NUM_SLAVES  per-slave read acks.
- up_rdata_s  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DATA_WIDTH+:DATA_WIDTH].
- up_status_clr  in  1  pulse; clears sticky flags and the counter.
- up_wack  out  1  merged write ack, 1-cycle pulse.
- up_rack  out  1  merged read ack, 1-cycle pulse.
- up_rdata  out  DATA_WIDTH  merged read data; valid with up_rack.
- up_timeout  out  2  sticky; [0] write timeout, [1] read timeout.
- up_multi_hit  out  1  sticky; more than one slave acked in one cycle.
- up_stray_ack  out  1  sticky; ack seen while that direction was IDLE.
- up_proto_err  out  1  sticky; request arrived while that direction was WAIT.
- up_err_count  out  16  saturating count of timeouts plus multi-hits.

## Operation
- Writes and reads each have an independent FSM with states IDLE and WAIT, plus a timeout counter of width clog2(TIMEOUT_CYCLES).
- IDLE → WAIT on the request pulse. The counter loads 0.
- In WAIT, the acks of that direction are sampled every cycle:
  - Any ack bit set: emit the merged ack and go to IDLE.
  - No ack and counter == TIMEOUT_CYCLES-1: forced completion. Emit the ack; for reads, up_rdata = TIMEOUT_RDATA. Set the up_timeout bit, increment up_err_count, go to IDLE.
  - Otherwise the counter increments.
- Read data is the OR over k of (up_rdata_s[k] AND all-ones if up_rack_s[k]). Slaves without an ack contribute 0.
- Two or more ack bits set in one sampled cycle: still complete normally (data ORed), set up_multi_hit, increment up_err_count.
- Acks while IDLE: ignored, no output pulse, set up_stray_ack.
- A request of the same direction while WAIT: ignored, set up_proto_err. The FSM and counter are unaffected.
- Write and read may be outstanding concurrently; no interaction between them.
- up_err_count saturates at 16'hFFFF. Two increments in one cycle (timeout on one direction, multi-hit on the other) add 2, still saturating.
- up_status_clr clears all sticky flags and the counter.
  - If an error event occurs in the same cycle as the clear, the event wins: flag = 1 and count = the event's increment.
- Reset (asynchronous) forces both FSMs to IDLE, counters to 0, and all outputs low/zero.
  - A transaction cut by reset is dropped; a late slave ack afterwards sets up_stray_ack.

## Timing
- Reset values: up_wack=0, up_rack=0, up_rdata=0, up_timeout=2'b00, up_multi_hit=0, up_stray_ack=0, up_proto_err=0, up_err_count=0.
- Request at cycle t gives WAIT from t+1. An ack present at t itself counts as stray.
- Slave ack sampled at cycle a: up_wack/up_rack high at a+1 (PIPELINE=0) or a+2 (PIPELINE=1), exactly one cycle wide. up_rdata is registered alongside the ack and is 0 when the ack is low.
- Forced completion: ack at t+1+TIMEOUT_CYCLES (PIPELINE=0), one cycle later with PIPELINE=1.
- Sticky flags and up_err_count update one cycle after the causing event, with PIPELINE=0. With PIPELINE=1 they update together with the corresponding output ack.
- The next request is accepted in the cycle after WAIT exits.

## Test plan
- NUM_SLAVES=4, PIPELINE=0: rreq at t, slave 2 drives rack with rdata 32'h1234_5678 at t+1 while the other slaves drive rdata 32'hFFFF_FFFF without rack → up_rack at t+2 with up_rdata=32'h1234_5678; no flags set.
- TIMEOUT_CYCLES=8: wreq with no slave ack → up_wack at t+9, up_timeout=2'b01, up_err_count=1. Repeat with rreq → up_rdata=32'hDEAD_DEAD, up_timeout=2'b11, count=2.
- Slaves 0 and 3 rack in the same cycle with 32'h0000_00F0 and 32'h0000_000F → up_rdata=32'h0000_00FF, up_multi_hit=1, count=1.
- Stray wack while IDLE → no up_wack, up_stray_ack=1. up_status_clr in the same cycle as a timeout → up_timeout set, count=1.
- Force up_err_count to 16'hFFFF, then a further timeout → count stays 16'hFFFF. Assert up_rstn=0 mid-WAIT → all outputs 0 immediately, no ack emitted after release.
- PIPELINE=1, concurrent wreq and rreq, wack at t+1 and rack at t+3 → up_wack at t+3, up_rack at t+5.

Source files
------------

// File: rtl/up_tpl_regmap_mux_if.sv
// Register-bus response-side bundle between up_axi, the TPL sub-blocks and the
// response aggregator.
interface up_tpl_regmap_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
);
  logic                             up_wreq;
  logic                             up_rreq;
  logic [NUM_SLAVES-1:0]            up_wack_s;
  logic [NUM_SLAVES-1:0]            up_rack_s;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] up_rdata_s;
  logic                             up_status_clr;
  logic                             up_wack;
  logic                             up_rack;
  logic [DATA_WIDTH-1:0]            up_rdata;
  logic [1:0]                       up_timeout;
  logic                             up_multi_hit;
  logic                             up_stray_ack;
  logic                             up_proto_err;
  logic [15:0]                      up_err_count;

  modport master (
    output up_wreq, up_rreq, up_wack_s, up_rack_s, up_rdata_s, up_status_clr,
    input  up_wack, up_rack, up_rdata, up_timeout, up_multi_hit, up_stray_ack,
           up_proto_err, up_err_count
  );

  modport slave (
    input  up_wreq, up_rreq, up_wack_s, up_rack_s, up_rdata_s, up_status_clr,
    output up_wack, up_rack, up_rdata, up_timeout, up_multi_hit, up_stray_ack,
           up_proto_err, up_err_count
  );
endinterface

// File: rtl/up_tpl_regmap_mux.sv
// Merges sub-block wack/rack/rdata into one registered response, tracking each
// direction with an IDLE/WAIT FSM and completing on timeout if nobody answers.
module up_tpl_regmap_mux_dir #(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic                  req,
  input  logic [NUM_SLAVES-1:0] ack_s,
  output logic                  done,
  output logic                  tmo,
  output logic                  multi,
  output logic                  stray,
  output logic                  proto
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic any_ack;

  assign any_ack = |ack_s;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    tmo       = 1'b0;
    multi     = 1'b0;
    stray     = 1'b0;
    proto     = 1'b0;
    case (state)
      S_IDLE: begin
        stray = any_ack;
        if (req) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        proto = req;
        // a real ack in the last wait cycle still beats the forced completion
        if (any_ack) begin
          done      = 1'b1;
          multi     = |(ack_s & (ack_s - 1'b1));
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          done      = 1'b1;
          tmo       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

module up_tpl_regmap_mux #(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD,
  parameter int                    PIPELINE       = 0
) (
  input logic                up_clk,
  input logic                up_rstn,
  up_tpl_regmap_mux_if.slave bus
);
  typedef struct packed {
    logic                  wack;
    logic                  rack;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            tmo;
    logic                  multi;
    logic                  stray;
    logic                  proto;
    logic [1:0]            inc;
  } evt_t;

  logic w_done, w_tmo, w_multi, w_stray, w_proto;
  logic r_done, r_tmo, r_multi, r_stray, r_proto;

  up_tpl_regmap_mux_dir #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
    .up_clk(up_clk), .up_rstn(up_rstn), .req(bus.up_wreq), .ack_s(bus.up_wack_s),
    .done(w_done), .tmo(w_tmo), .multi(w_multi), .stray(w_stray), .proto(w_proto)
  );

  up_tpl_regmap_mux_dir #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
    .up_clk(up_clk), .up_rstn(up_rstn), .req(bus.up_rreq), .ack_s(bus.up_rack_s),
    .done(r_done), .tmo(r_tmo), .multi(r_multi), .stray(r_stray), .proto(r_proto)
  );

  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] rdata_g;
  logic [DATA_WIDTH-1:0]                 rdata_or;

  // slaves that did not rack contribute nothing, whatever they leave on the bus
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_gate
    assign rdata_g[k] = bus.up_rdata_s[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{bus.up_rack_s[k]}};
  end

  always_comb begin
    rdata_or = '0;
    for (int k = 0; k < NUM_SLAVES; k++) rdata_or |= rdata_g[k];
  end

  evt_t ev_d, ev_q;

  always_comb begin
    ev_d       = '0;
    ev_d.wack  = w_done;
    ev_d.rack  = r_done;
    ev_d.rdata = !r_done ? '0 : (r_tmo ? TIMEOUT_RDATA : rdata_or);
    ev_d.tmo   = {r_tmo, w_tmo};
    ev_d.multi = w_multi | r_multi;
    ev_d.stray = w_stray | r_stray;
    ev_d.proto = w_proto | r_proto;
    ev_d.inc   = 2'(w_tmo) + 2'(r_tmo) + 2'(w_multi) + 2'(r_multi);
  end

  if (PIPELINE != 0) begin : g_pipe
    always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) ev_q <= '0;
      else          ev_q <= ev_d;
    end
  end else begin : g_nopipe
    assign ev_q = ev_d;
  end

  logic                  wack_q, rack_q, multi_q, stray_q, proto_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            tmo_q;
  logic [15:0]           cnt_q;
  logic                  clr;
  logic [16:0]           cnt_sum;

  // a clear coinciding with an event drops the old state but keeps the event
  assign clr     = bus.up_status_clr;
  assign cnt_sum = {1'b0, (clr ? 16'h0 : cnt_q)} + {15'd0, ev_q.inc};

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= 2'b00;
      multi_q <= 1'b0;
      stray_q <= 1'b0;
      proto_q <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      wack_q  <= ev_q.wack;
      rack_q  <= ev_q.rack;
      rdata_q <= ev_q.rdata;
      tmo_q   <= (tmo_q & {2{~clr}}) | ev_q.tmo;
      multi_q <= (multi_q & ~clr) | ev_q.multi;
      stray_q <= (stray_q & ~clr) | ev_q.stray;
      proto_q <= (proto_q & ~clr) | ev_q.proto;
      cnt_q   <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign bus.up_wack      = wack_q;
  assign bus.up_rack      = rack_q;
  assign bus.up_rdata     = rdata_q;
  assign bus.up_timeout   = tmo_q;
  assign bus.up_multi_hit = multi_q;
  assign bus.up_stray_ack = stray_q;
  assign bus.up_proto_err = proto_q;
  assign bus.up_err_count = cnt_q;
endmodule
